// File: rtl/rr_arbiter_4req.sv
// Four-requester arbiter with round-robin scheduling and a per-ownership hold limit.
// Define ARB_FIXED_PRIORITY_EN to replace round-robin with fixed priority (highest index wins).
module rr_arbiter_4req #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam bit   HOLD_EN  = (MAX_HOLD != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       gnt_n;
    logic [1:0]       gnt_id_n;
    logic             gnt_valid_n;
    logic             timeout_n;
    logic [1:0]       win_idx;

`ifndef ARB_FIXED_PRIORITY_EN
    logic [1:0]       last, last_n;
`endif

    // Winner selection; later loop iterations override earlier ones.
    always_comb begin
        win_idx = 2'd0;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 4; i++) begin
            if (req[i]) win_idx = 2'(i);
        end
`else
        // Walk the search order backwards so the first hit after last wins.
        for (int k = 4; k >= 1; k--) begin
            if (req[last + 2'(k)]) win_idx = last + 2'(k);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt       <= 4'd0;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
            last      <= 2'd3;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            gnt_id    <= gnt_id_n;
            gnt_valid <= gnt_valid_n;
            timeout   <= timeout_n;
`ifndef ARB_FIXED_PRIORITY_EN
            last      <= last_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        gnt_n       = gnt;
        gnt_id_n    = gnt_id;
        gnt_valid_n = gnt_valid;
        timeout_n   = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
        last_n      = last;
`endif
        case (state)
            IDLE: begin
                gnt_n       = 4'd0;
                gnt_id_n    = 2'd0;
                gnt_valid_n = 1'b0;
                cnt_n       = '0;
                if (|req) begin
                    state_n     = GRANT;
                    cnt_n       = CNT_W'(1);
                    gnt_n       = 4'(4'b0001 << win_idx);
                    gnt_id_n    = win_idx;
                    gnt_valid_n = 1'b1;
`ifndef ARB_FIXED_PRIORITY_EN
                    last_n      = win_idx;
`endif
                end
            end
            GRANT: begin
                // Release beats revocation, so timeout only fires while the owner still requests.
                if (!req[gnt_id] || (HOLD_EN && cnt == HOLD_LIM)) begin
                    state_n     = IDLE;
                    cnt_n       = '0;
                    gnt_n       = 4'd0;
                    gnt_id_n    = 2'd0;
                    gnt_valid_n = 1'b0;
                    timeout_n   = req[gnt_id];
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter_4req.sv
// Self-checking bench for rr_arbiter_4req: cycle model feeding a scoreboard queue plus directed checks.
module tb_rr_arbiter_4req;

    localparam int unsigned HOLD = 4;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'd0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    logic [3:0] nl_gnt;
    logic [1:0] nl_gnt_id;
    logic       nl_gnt_valid;
    logic       nl_timeout;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    bit   m_busy;
    int   m_owner;
    int   m_cnt;
    int   m_last;

    rr_arbiter_4req #(.MAX_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    rr_arbiter_4req #(.MAX_HOLD(0)) dut_nl (
        .clk(clk), .rst(rst), .req(req),
        .gnt(nl_gnt), .gnt_id(nl_gnt_id), .gnt_valid(nl_gnt_valid), .timeout(nl_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int l);
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 3; i >= 0; i--) if (r[i]) return i;
        return 0;
`else
        for (int k = 1; k <= 4; k++) if (r[(l + k) % 4]) return (l + k) % 4;
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_cnt   = 0;
        m_last  = 3;
        q.delete();
    endtask

    // Predict the registered outputs after the next edge for request pattern r.
    task automatic predict(input logic [3:0] r);
        exp_t e;
        e = '0;
        if (!m_busy) begin
            if (r != 4'd0) begin
                m_owner = pick(r, m_last);
                m_last  = m_owner;
                m_busy  = 1'b1;
                m_cnt   = 1;
                e.gnt   = 4'(1 << m_owner);
                e.id    = 2'(m_owner);
                e.valid = 1'b1;
            end
        end else if (!r[m_owner]) begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (m_cnt == HOLD) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            e.to   = 1'b1;
        end else begin
            m_cnt   = m_cnt + 1;
            e.gnt   = 4'(1 << m_owner);
            e.id    = 2'(m_owner);
            e.valid = 1'b1;
        end
        q.push_back(e);
    endtask

    task automatic cyc(input logic [3:0] r);
        exp_t e;
        req = r;
        predict(r);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("sb_gnt", 32'(gnt), 32'(e.gnt));
        chk("sb_id", 32'(gnt_id), 32'(e.id));
        chk("sb_valid", 32'(gnt_valid), 32'(e.valid));
        chk("sb_timeout", 32'(timeout), 32'(e.to));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(gnt_valid), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int order[5];
        int nl_to_seen;
        logic [3:0] r;

        model_reset();
        #3;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_id", 32'(gnt_id), 32'h0);
        chk("reset_valid", 32'(gnt_valid), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);
        do_reset();

        // Single requester: latency 1, release gives idle next edge.
        cyc(4'b0001);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_id", 32'(gnt_id), 32'h0);
        chk("t1_valid", 32'(gnt_valid), 32'h1);
        cyc(4'b0001);
        cyc(4'b0001);
        cyc(4'b0000);
        chk("t1_release", 32'(gnt), 32'h0);

        // Round-robin rotation with all four requesting.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(4'b1111);
            order[k] = int'(gnt_id);
            cyc(4'b1111);
            r = 4'b1111;
            r[k % 4] = 1'b0;
            cyc(r);
            chk("rr_dead", 32'(gnt_valid), 32'h0);
        end
`ifndef ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < 5; k++) chk("rr_order", 32'(order[k]), 32'(k % 4));
`endif

        // Hold limit revokes owner 0; owner 1 wins next.
        do_reset();
        cyc(4'b0011);
        chk("to_first", 32'(gnt), 32'h1);
        for (int k = 0; k < 3; k++) cyc(4'b0011);
        chk("to_still", 32'(gnt), 32'h1);
        cyc(4'b0011);
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_gnt0", 32'(gnt), 32'h0);
        cyc(4'b0011);
        chk("to_pulse_end", 32'(timeout), 32'h0);
`ifndef ARB_FIXED_PRIORITY_EN
        chk("to_next", 32'(gnt), 32'h2);
`endif

        // Release on the same cycle the limit is reached: no timeout.
        do_reset();
        for (int k = 0; k < 4; k++) cyc(4'b0001);
        cyc(4'b0000);
        chk("rel_lim_to", 32'(timeout), 32'h0);
        chk("rel_lim_valid", 32'(gnt_valid), 32'h0);
        cyc(4'b0001);
        chk("rel_lim_regrant", 32'(gnt), 32'h1);

        // Asynchronous reset mid-grant.
        do_reset();
        cyc(4'b0100);
        cyc(4'b0100);
        chk("ar_pre", 32'(gnt), 32'h4);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_id", 32'(gnt_id), 32'h0);
        chk("ar_valid", 32'(gnt_valid), 32'h0);
        chk("ar_timeout", 32'(timeout), 32'h0);
        req = 4'b1000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc(4'b1000);
        chk("ar_after_gnt", 32'(gnt), 32'h8);
        chk("ar_after_id", 32'(gnt_id), 32'h3);

`ifdef ARB_FIXED_PRIORITY_EN
        do_reset();
        cyc(4'b0110);
        chk("fp_first", 32'(gnt_id), 32'h2);
        for (int k = 0; k < 2; k++) begin
            cyc(4'b0010);
            cyc(4'b0110);
            chk("fp_again", 32'(gnt_id), 32'h2);
        end
`endif

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 60; k++) cyc(4'($urandom_range(0, 15)));

        // Disabled limit: one owner holds well past counter saturation.
        do_reset();
        nl_to_seen = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(4'b0001);
            if (nl_timeout) nl_to_seen++;
        end
        chk("nl_no_timeout", 32'(nl_to_seen), 32'h0);
        chk("nl_gnt", 32'(nl_gnt), 32'h1);
        chk("nl_valid", 32'(nl_gnt_valid), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
